// File: rtl/instr_issue_seq_if.sv
// rtl/instr_issue_seq_if.sv - program ROM port and issue handshake bundle for instr_issue_seq
interface instr_issue_seq_if #(
  parameter int ADDR_W = 8
) ();
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_data;
  logic              issue_valid;
  logic              issue_ready;
  logic [3:0]        issue_opcode;
  logic [3:0]        issue_rd;
  logic [3:0]        issue_rs1;
  logic [3:0]        issue_rs2;

  modport master (
    output imem_en, imem_addr,
    input  imem_data,
    output issue_valid, issue_opcode, issue_rd, issue_rs1, issue_rs2,
    input  issue_ready
  );

  modport slave (
    input  imem_en, imem_addr,
    output imem_data,
    input  issue_valid, issue_opcode, issue_rd, issue_rs1, issue_rs2,
    output issue_ready
  );
endinterface

// File: rtl/instr_issue_seq.sv
// rtl/instr_issue_seq.sv - instruction fetch/issue sequencer; optional NOP_SKIP_EN drops opcode 0 instead of issuing it
module instr_issue_seq #(
  parameter int         ADDR_W      = 8,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  instr_issue_seq_if.master     bus,
  output logic [ADDR_W-1:0]     pc,
  output logic                  busy,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic [15:0]       ir;

  // State, program counter and instruction register; ROM data is only trusted in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (state == S_WAIT) begin
        ir <= bus.imem_data;
      end
    end
  end

  // Next-state and next-pc; start only matters when idle or halted, ready only in ISSUE.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_nx    = '0;
          state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_data[15:12] == HALT_OPCODE) begin
          state_nx = S_HALT;
`ifdef NOP_SKIP_EN
        end else if (bus.imem_data[15:12] == 4'h0) begin
          pc_nx    = pc + PC_ONE;
          state_nx = S_FETCH;
`endif
        end else begin
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.issue_ready) begin
          pc_nx    = pc + PC_ONE;
          state_nx = S_FETCH;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // The ROM read is a single-cycle strobe in FETCH; the address is parked at zero otherwise.
  assign bus.imem_en   = (state == S_FETCH);
  assign bus.imem_addr = (state == S_FETCH) ? pc : '0;

  // Fields come straight from the instruction register so they hold through stalls and after handshake.
  assign bus.issue_valid  = (state == S_ISSUE);
  assign bus.issue_opcode = ir[15:12];
  assign bus.issue_rd     = ir[11:8];
  assign bus.issue_rs1    = ir[7:4];
  assign bus.issue_rs2    = ir[3:0];

  assign busy   = (state == S_FETCH) || (state == S_WAIT) || (state == S_ISSUE);
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_instr_issue_seq.sv
// tb/tb_instr_issue_seq.sv - scoreboard bench for instr_issue_seq with a program-walking reference model
module tb_instr_issue_seq;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;

  instr_issue_seq_if #(.ADDR_W(ADDR_W)) bus ();

  instr_issue_seq #(.ADDR_W(ADDR_W), .HALT_OPCODE(4'hF)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bus    (bus),
    .pc     (pc),
    .busy   (busy),
    .halted (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]       word;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] rom [DEPTH];
  int          n_checks = 0;
  int          n_fails  = 0;
  int          ready_mode = 0;
  logic        ready_manual = 1'b0;

  // synchronous program ROM
  always @(posedge clk) begin
    if (bus.imem_en === 1'b1) bus.imem_data <= rom[bus.imem_addr];
  end

  // ready driver: 0 = always ready, 1 = random, 2 = manual
  initial begin
    bus.issue_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      bus.issue_ready = 1'b1;
      else if (ready_mode == 1) bus.issue_ready = 1'($urandom_range(0, 1));
      else                      bus.issue_ready = ready_manual;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every valid cycle must show the scoreboard head; pop on handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.issue_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_issue: got op %0h at pc %0d expected no issue", bus.issue_opcode, pc);
        end else begin
          e = sb[0];
          check("issue_fields", 32'({bus.issue_opcode, bus.issue_rd, bus.issue_rs1, bus.issue_rs2}), 32'(e.word));
          check("issue_pc", 32'(pc), 32'(e.addr));
          if (bus.issue_ready === 1'b1) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    tick();
    tick();
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Walk the program from address 0 the way the sequencer is meant to, queueing each issued word.
  task automatic build_expect(input int n_max, output bit halts, output int halt_pc);
    int a;
    int issued;
    logic [15:0] w;
    a = 0;
    issued = 0;
    halts = 1'b0;
    halt_pc = 0;
    for (int step = 0; step < 4 * DEPTH && issued < n_max; step++) begin
      w = rom[a];
      if (w[15:12] == 4'hF) begin
        halts = 1'b1;
        halt_pc = a;
        break;
      end
`ifdef NOP_SKIP_EN
      if (w[15:12] == 4'h0) begin
        a = (a + 1) % DEPTH;
        continue;
      end
`endif
      sb.push_back('{word: w, addr: a[ADDR_W-1:0]});
      issued++;
      a = (a + 1) % DEPTH;
    end
  endtask

  task automatic wait_done(input bit halts, input int halt_pc, input string tag);
    int cyc;
    cyc = 0;
    while (!(sb.size() == 0 && (!halts || halted === 1'b1)) && cyc < 6000) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc >= 6000) begin
      n_fails++;
      $display("FAIL %s_timeout: got %0d pending expected 0", tag, sb.size());
    end
    if (halts) begin
      check({tag, "_halted"}, 32'(halted), 32'd1);
      check({tag, "_halt_pc"}, 32'(pc), 32'(halt_pc));
      check({tag, "_halt_valid"}, 32'(bus.issue_valid), 32'd0);
      check({tag, "_halt_busy"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic wait_valid(input string tag);
    int cyc;
    cyc = 0;
    while (bus.issue_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_valid_seen"}, 32'(bus.issue_valid), 32'd1);
  endtask

  task automatic gen_prog(input int len, input bit with_halt);
    logic [3:0] op;
    for (int i = 0; i < DEPTH; i++) begin
      op = 4'($urandom_range(0, 14));
      rom[i] = {op, 12'($urandom)};
    end
    if (with_halt) rom[len] = {4'hF, 12'($urandom)};
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_imem_en"}, 32'(bus.imem_en), 32'd0);
    check({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
    check({tag, "_valid"}, 32'(bus.issue_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bit halts;
    int hpc;
    rst   = 1'b1;
    start = 1'b0;
    tick();
    tick();
    check_idle("reset");
    check("reset_fields", 32'({bus.issue_opcode, bus.issue_rd, bus.issue_rs1, bus.issue_rs2}), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    check_idle("idle_hold");

    // directed program with latency probe
    gen_prog(3, 1'b1);
    rom[0] = 16'h1123; rom[1] = 16'h2456; rom[2] = 16'hF000;
    ready_mode = 0;
    build_expect(DEPTH, halts, hpc);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("fetch_imem_en", 32'(bus.imem_en), 32'd1);
    check("fetch_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("fetch_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("wait_imem_en", 32'(bus.imem_en), 32'd0);
    @(negedge clk);
    check("latency_valid", 32'(bus.issue_valid), 32'd1);
    wait_done(halts, hpc, "t1");
    check("t1_halt_pc_abs", 32'(pc), 32'd2);

    // stall holds fields
    do_reset();
    rom[0] = 16'h3ABC; rom[1] = 16'hF000;
    ready_mode = 2;
    ready_manual = 1'b0;
    build_expect(DEPTH, halts, hpc);
    pulse_start();
    wait_valid("t2");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.issue_valid), 32'd1);
      check("stall_fields", 32'({bus.issue_opcode, bus.issue_rd, bus.issue_rs1, bus.issue_rs2}), 32'h3ABC);
      check("stall_pc", 32'(pc), 32'd0);
    end
    ready_manual = 1'b1;
    tick();
    wait_done(halts, hpc, "t2");
    check("t2_halt_pc_abs", 32'(pc), 32'd1);

    // full pass with pc wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) rom[i] = {4'($urandom_range(1, 14)), 12'($urandom)};
    ready_mode = 0;
    build_expect(DEPTH + 4, halts, hpc);
    pulse_start();
    wait_done(halts, hpc, "t3");
    do_reset();

    // opcode 0 handling
    gen_prog(3, 1'b1);
    rom[0] = 16'h0000; rom[1] = 16'h7123; rom[2] = 16'hF000;
    ready_mode = 1;
    build_expect(DEPTH, halts, hpc);
    pulse_start();
    wait_done(halts, hpc, "t4");

    // reset mid-handshake drops the instruction
    do_reset();
    gen_prog(6, 1'b1);
    rom[0] = 16'h5ABC;
    ready_mode = 2;
    ready_manual = 1'b0;
    build_expect(DEPTH, halts, hpc);
    pulse_start();
    wait_valid("t5");
    rst = 1'b1;
    tick();
    check("rst_valid", 32'(bus.issue_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    sb.delete();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_no_fetch", 32'(bus.imem_en), 32'd0);
    end
    tick();

    // start ignored while busy, honoured in HALT
    gen_prog(5, 1'b1);
    rom[0] = 16'h9876;
    ready_mode = 2;
    ready_manual = 1'b0;
    build_expect(DEPTH, halts, hpc);
    pulse_start();
    wait_valid("t6");
    pulse_start();
    @(negedge clk);
    check("busy_start_valid", 32'(bus.issue_valid), 32'd1);
    check("busy_start_pc", 32'(pc), 32'd0);
    ready_manual = 1'b1;
    tick();
    wait_done(halts, hpc, "t6a");
    ready_mode = 0;
    build_expect(DEPTH, halts, hpc);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("restart_imem_en", 32'(bus.imem_en), 32'd1);
    check("restart_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("restart_halted", 32'(halted), 32'd0);
    wait_done(halts, hpc, "t6b");

    // random programs, random backpressure, restart from HALT or reset
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) do_reset();
      gen_prog($urandom_range(1, 12), 1'b1);
      ready_mode = 1;
      build_expect(DEPTH, halts, hpc);
      pulse_start();
      wait_done(halts, hpc, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
